// File: rtl/ava_irq_ctrl.sv
// AVA interrupt controller: N level/edge sources with pending, enable,
// W1C clear and sticky overflow, one registered interrupt line to the core.
module ava_irq_ctrl #(
  parameter int unsigned          N_SOURCES    = 2,
  parameter logic [N_SOURCES-1:0] EDGE_MASK    = N_SOURCES'(1),
  parameter logic [N_SOURCES-1:0] RESET_ENABLE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SOURCES-1:0] src_i,
  input  logic                 reg_addr,
  input  logic                 reg_we,
  input  logic                 reg_re,
  input  logic [31:0]          reg_wdata,
  output logic [31:0]          reg_rdata,
  output logic                 irq_o
);

  if (N_SOURCES < 1 || N_SOURCES > 16) begin : g_bad_n
    $error("ava_irq_ctrl: N_SOURCES must be in 1..16");
  end

  logic [N_SOURCES-1:0] src_q;
  logic [N_SOURCES-1:0] pending;
  logic [N_SOURCES-1:0] enable;
  logic [N_SOURCES-1:0] overflow;

  logic [N_SOURCES-1:0] evt;
  logic [N_SOURCES-1:0] pend_w1c;
  logic [N_SOURCES-1:0] ovf_w1c;
  logic [N_SOURCES-1:0] ovf_set;
  logic                 ctrl_wr;
  logic                 ovf_wr;
  logic [31:0]          ctrl_view;
  logic [31:0]          ovf_view;

  // Upper write-data bits are architecturally ignored.
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata;

  always_comb begin
    ctrl_wr  = reg_we && !reg_addr;
    ovf_wr   = reg_we && reg_addr;
    evt      = (src_i & ~src_q & EDGE_MASK) | (src_i & ~EDGE_MASK);
    pend_w1c = ctrl_wr ? reg_wdata[N_SOURCES-1:0] : '0;
    ovf_w1c  = ovf_wr  ? reg_wdata[N_SOURCES-1:0] : '0;
    // An edge is lost only if the pending bit survives this cycle anyway.
    ovf_set  = evt & pending & ~pend_w1c & EDGE_MASK;
  end

  always_comb begin
    ctrl_view = '0;
    ctrl_view[N_SOURCES-1:0]           = pending;
    ctrl_view[2*N_SOURCES-1:N_SOURCES] = enable;
    ovf_view  = '0;
    ovf_view[N_SOURCES-1:0]            = overflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q     <= '0;
      pending   <= '0;
      enable    <= RESET_ENABLE;
      overflow  <= '0;
      reg_rdata <= '0;
      irq_o     <= 1'b0;
    end else begin
      src_q    <= src_i;
      pending  <= (pending & ~pend_w1c) | evt;
      overflow <= ((overflow & ~ovf_w1c) | ovf_set) & EDGE_MASK;
      if (ctrl_wr) begin
        enable <= reg_wdata[2*N_SOURCES-1:N_SOURCES];
      end
      if (reg_re) begin
        reg_rdata <= reg_addr ? ovf_view : ctrl_view;
      end
      irq_o <= |(pending & enable);
    end
  end

endmodule

// File: tb/tb_ava_irq_ctrl.sv
// Scoreboard bench for ava_irq_ctrl: a per-source behavioural model predicts
// irq_o every cycle and read data for every read; a monitor compares.
module tb_ava_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] src;
  logic        reg_addr;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  ava_irq_ctrl #(
    .N_SOURCES   (2),
    .EDGE_MASK   (2'b01),
    .RESET_ENABLE(2'b00)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .src_i    (src[1:0]),
    .reg_addr (reg_addr),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_wdata(reg_wdata),
    .reg_rdata(rdata_a),
    .irq_o    (irq_a)
  );

  ava_irq_ctrl #(
    .N_SOURCES   (16),
    .EDGE_MASK   (16'hFFFF),
    .RESET_ENABLE(16'h00F0)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .src_i    (src),
    .reg_addr (reg_addr),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_wdata(reg_wdata),
    .reg_rdata(rdata_b),
    .irq_o    (irq_b)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_qa[$];
  logic [31:0] rd_qb[$];
  logic        irq_qa[$];
  logic        irq_qb[$];

  // Reference model state, one row per instance, one column per source.
  bit m_pend [2][16];
  bit m_en   [2][16];
  bit m_ovf  [2][16];
  bit m_prev [2][16];

  function automatic int n_of(input int inst);
    return (inst == 0) ? 2 : 16;
  endfunction

  function automatic bit is_edge(input int inst, input int i);
    if (inst == 1) return 1'b1;
    return (i == 0);
  endfunction

  function automatic bit reset_en(input int inst, input int i);
    if (inst == 1) return (i >= 4 && i <= 7);
    return 1'b0;
  endfunction

  task automatic model_cycle(input bit r, input logic [15:0] s, input bit a,
                             input bit w, input bit rd, input logic [31:0] wd);
    for (int inst = 0; inst < 2; inst++) begin
      int n = n_of(inst);
      bit any = 1'b0;
      logic [31:0] val = '0;
      if (r) begin
        for (int i = 0; i < n; i++) begin
          m_pend[inst][i] = 0;
          m_ovf[inst][i]  = 0;
          m_prev[inst][i] = 0;
          m_en[inst][i]   = reset_en(inst, i);
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          if (m_pend[inst][i] && m_en[inst][i]) any = 1'b1;
          if (a) val[i] = m_ovf[inst][i];
          else begin
            val[i]     = m_pend[inst][i];
            val[n + i] = m_en[inst][i];
          end
        end
        for (int i = 0; i < n; i++) begin
          bit ev, clr, oclr;
          ev   = is_edge(inst, i) ? (s[i] && !m_prev[inst][i]) : s[i];
          clr  = w && !a && wd[i];
          oclr = w && a && wd[i];
          if (is_edge(inst, i) && ev && m_pend[inst][i] && !clr) m_ovf[inst][i] = 1;
          else if (oclr) m_ovf[inst][i] = 0;
          if (ev) m_pend[inst][i] = 1;
          else if (clr) m_pend[inst][i] = 0;
          if (w && !a) m_en[inst][i] = wd[n + i];
          m_prev[inst][i] = s[i];
        end
      end
      if (inst == 0) begin
        irq_qa.push_back(any);
        if (rd && !r) rd_qa.push_back(val);
      end else begin
        irq_qb.push_back(any);
        if (rd && !r) rd_qb.push_back(val);
      end
    end
  endtask

  task automatic step(input bit r, input logic [15:0] s, input bit a,
                      input bit w, input bit rd, input logic [31:0] wd);
    rst = r; src = s; reg_addr = a; reg_we = w; reg_re = rd; reg_wdata = wd;
    model_cycle(r, s, a, w, rd, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [15:0] s);
    step(0, s, 0, 0, 0, '0);
  endtask

  task automatic rd_reg(input logic [15:0] s, input bit a);
    step(0, s, a, 0, 1, '0);
  endtask

  task automatic wr_reg(input logic [15:0] s, input bit a, input logic [31:0] d);
    step(0, s, a, 1, 0, d);
  endtask

  // Monitor: read data is presented the cycle after a non-reset read strobe.
  logic re_seen = 1'b0;
  always @(posedge clk) re_seen <= reg_re && !rst;

  always @(negedge clk) begin
    logic [31:0] exp_d;
    logic        exp_i;
    if (irq_qa.size() > 0) begin
      exp_i = irq_qa.pop_front();
      total++;
      if (irq_a !== exp_i) begin
        bad++;
        $display("FAIL irq_a t=%0t got=%0b want=%0b", $time, irq_a, exp_i);
      end
    end
    if (irq_qb.size() > 0) begin
      exp_i = irq_qb.pop_front();
      total++;
      if (irq_b !== exp_i) begin
        bad++;
        $display("FAIL irq_b t=%0t got=%0b want=%0b", $time, irq_b, exp_i);
      end
    end
    if (re_seen) begin
      total += 2;
      if (rd_qa.size() == 0 || rd_qb.size() == 0) begin
        bad++;
        $display("FAIL rd_queue t=%0t read seen with no expectation", $time);
      end else begin
        exp_d = rd_qa.pop_front();
        if (rdata_a !== exp_d) begin
          bad++;
          $display("FAIL rdata_a t=%0t got=%h want=%h", $time, rdata_a, exp_d);
        end
        exp_d = rd_qb.pop_front();
        if (rdata_b !== exp_d) begin
          bad++;
          $display("FAIL rdata_b t=%0t got=%h want=%h", $time, rdata_b, exp_d);
        end
      end
    end
  end

  initial begin
    step(1, '0, 0, 0, 0, '0);
    step(1, '0, 0, 0, 0, '0);
    rd_reg('0, 0);
    rd_reg('0, 1);
    idle('0);

    // Enabled edge source: pend/irq latency, then W1C keeps enable.
    wr_reg('0, 0, 32'h4);
    idle(16'h0001);
    idle('0); idle('0); idle('0);
    rd_reg('0, 0);
    wr_reg('0, 0, 32'h5);
    idle('0); idle('0); idle('0);
    rd_reg('0, 0);

    // Overflow on a second edge, overflow W1C, edge racing a pending W1C.
    idle(16'h0001); idle('0); idle(16'h0001); idle('0);
    rd_reg('0, 1);
    wr_reg('0, 1, 32'h1);
    rd_reg('0, 1);
    step(0, 16'h0001, 0, 1, 0, 32'h5);
    rd_reg('0, 0);
    rd_reg('0, 1);
    wr_reg('0, 0, 32'h5);

    // Level source held high: W1C re-sets until the source drops.
    wr_reg('0, 0, 32'h8);
    idle(16'h0002); idle(16'h0002);
    wr_reg(16'h0002, 0, 32'hA);
    idle(16'h0002); idle(16'h0002);
    rd_reg(16'h0002, 0);
    idle('0);
    wr_reg('0, 0, 32'hA);
    idle('0); idle('0);
    rd_reg('0, 0);

    // Disabled source still latches pending; enabling later raises irq.
    wr_reg('0, 0, 32'h0);
    idle(16'h0001); idle('0); idle('0);
    wr_reg('0, 0, 32'h4);
    idle('0); idle('0); idle('0);

    // All sources at once, then reset in the middle of a burst.
    wr_reg('0, 0, 32'h3);
    idle(16'hFFFF); idle('0);
    rd_reg('0, 0);
    idle(16'hFFFF); idle('0); idle(16'hFFFF);
    step(1, 16'hFFFF, 0, 1, 1, 32'hFFFF_FFFF);
    rd_reg('0, 0);
    rd_reg('0, 1);
    idle('0);

    for (int k = 0; k < 3000; k++) begin
      bit r  = ($urandom_range(0, 199) == 0);
      bit a  = $urandom_range(0, 1);
      bit w  = ($urandom_range(0, 3) == 0);
      bit rd = ($urandom_range(0, 2) == 0);
      logic [15:0] s  = 16'($urandom);
      logic [31:0] wd = $urandom;
      step(r, s, a, w, rd, wd);
    end

    step(0, '0, 0, 0, 0, '0);
    @(negedge clk);
    #1;
    total++;
    if (irq_qa.size() + irq_qb.size() + rd_qa.size() + rd_qb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d leftover want=0",
               irq_qa.size() + irq_qb.size() + rd_qa.size() + rd_qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
